// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: decides advance/hold/squash per stage, owns memory watchdog and stall counter.
// Controls are combinational from state+inputs; state, watchdog, drain and stall counters are registered.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT  = 255,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       id_rs,
    input  logic             id_rs_used,
    input  logic [2:0]       id_rt,
    input  logic             id_rt_used,
    input  logic             id_halt,
    input  logic [2:0]       ex_dest,
    input  logic             ex_dest_valid,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_flush,
    output logic             ex_mem_we,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);
    localparam int DRN_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] TMO      = WAIT_W'(MEM_TIMEOUT);
    localparam logic [DRN_W-1:0]  DRN_INIT = DRN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} state_t;

    state_t             state, state_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
    logic [DRN_W-1:0]   drain_cnt, drain_nxt;
    logic               fault_set;
    logic               mem_hold, lduse, hold;

    assign mem_hold = mem_req & ~mem_ready;
    assign lduse    = ex_is_load & ex_dest_valid &
                      ((id_rs_used & (id_rs == ex_dest)) | (id_rt_used & (id_rt == ex_dest)));
    // Once waiting, only mem_ready releases the freeze.
    assign hold     = (state == MEMWAIT) ? ~mem_ready : mem_hold;
    assign halted   = (state == HALTED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            stall_cnt <= '0;
            mem_fault <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            drain_cnt <= drain_nxt;
            if (fault_set)
                mem_fault <= 1'b1;
            if (!pc_we && state != HALTED && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        drain_nxt = drain_cnt;
        fault_set = 1'b0;
        case (state)
            RUN, MEMWAIT, DRAIN: begin
                if (hold) begin
                    if (state == RUN) begin
                        state_nxt = MEMWAIT;
                        wait_nxt  = WAIT_W'(1);
                    end else if (wait_cnt == TMO) begin
                        fault_set = 1'b1;
                        state_nxt = HALTED;
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end else begin
                    wait_nxt = '0;
                    if (state == DRAIN) begin
                        if (drain_cnt == '0)
                            state_nxt = HALTED;
                        else
                            drain_nxt = drain_cnt - 1'b1;
                    end else if (!ex_branch_taken && !lduse && id_halt) begin
                        state_nxt = DRAIN;
                        drain_nxt = DRN_INIT;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_we     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_we    = 1'b1;
        mem_wb_flush = 1'b0;
        if (!rst_n) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (state == HALTED) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
        end else if (hold) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (state == DRAIN) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (lduse || id_halt) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end
endmodule
